// File: rtl/router_pkg.sv
// Shared types and defaults for the router packet transmitter.
package router_pkg;

  localparam int unsigned AddrW   = 2;
  localparam int unsigned LenW    = 6;
  localparam int unsigned DataW   = AddrW + LenW;
  localparam int unsigned ErrWait = 3;
  localparam int unsigned MaxAddr = 2;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StHeader,
    StPayload,
    StParity,
    StErrWait
  } tx_state_e;

  // Header byte carries the length in the upper bits and the destination in the lower bits.
  function automatic logic [DataW-1:0] pack_header(input logic [LenW-1:0]  len,
                                                   input logic [AddrW-1:0] addr);
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_tx_buffer.sv
// Payload store: synchronous write, combinational read so the next byte is ready one edge after
// acceptance.
module router_tx_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IDX_W  = 6
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_byte,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_byte
);

  localparam int unsigned Depth = 1 << IDX_W;

  logic [DATA_W-1:0] mem_q [Depth];

  // Contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_byte;
    end
  end

  assign rd_byte = mem_q[rd_idx];

endmodule

// File: rtl/router_pkt_tx.sv
// Router input-port packet source: buffers a full payload, then sends header, payload and
// parity with busy back-pressure and reports the router's err flag after a fixed window.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned ADDR_W   = AddrW,
  parameter int unsigned LEN_W    = LenW,
  parameter int unsigned DATA_W   = DataW,
  parameter int unsigned ERR_WAIT = ErrWait
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              cmd_reject,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              busy,
  input  logic              err,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              tx_done,
  output logic              tx_err
);

  localparam int unsigned CntW = $clog2(ERR_WAIT + 1);

  tx_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] par_q, par_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              flag_q, flag_d;
  logic              pkt_valid_q, pkt_valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              reject_q, reject_d;
  logic              done_q, done_d;
  logic              terr_q, terr_d;

  logic              buf_we;
  logic [LEN_W-1:0]  buf_rd_idx;
  logic [DATA_W-1:0] buf_rd_byte;

  router_tx_buffer #(
    .DATA_W (DATA_W),
    .IDX_W  (LEN_W)
  ) u_buffer (
    .clock   (clock),
    .wr_en   (buf_we),
    .wr_idx  (idx_q),
    .wr_byte (wr_data),
    .rd_idx  (buf_rd_idx),
    .rd_byte (buf_rd_byte)
  );

  assign cmd_ready  = (state_q == StIdle);
  assign wr_ready   = (state_q == StFill);
  assign cmd_reject = reject_q;
  assign pkt_valid  = pkt_valid_q;
  assign data_out   = data_q;
  assign tx_done    = done_q;
  assign tx_err     = terr_q;

  // Next-state, counters, parity and registered router outputs.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    par_d       = par_q;
    cnt_d       = cnt_q;
    flag_d      = flag_q;
    pkt_valid_d = pkt_valid_q;
    data_d      = data_q;
    reject_d    = 1'b0;
    done_d      = 1'b0;
    terr_d      = 1'b0;
    buf_we      = 1'b0;
    buf_rd_idx  = idx_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_len == '0 || cmd_addr > ADDR_W'(MaxAddr)) begin
            reject_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            len_d   = cmd_len;
            par_d   = pack_header(cmd_len, cmd_addr);
            idx_d   = '0;
            state_d = StFill;
          end
        end
      end

      StFill: begin
        if (wr_valid) begin
          buf_we = 1'b1;
          par_d  = par_q ^ wr_data;
          idx_d  = idx_q + LEN_W'(1);
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d     = StHeader;
            pkt_valid_d = 1'b1;
            data_d      = pack_header(len_q, addr_q);
            idx_d       = '0;
          end
        end
      end

      StHeader: begin
        buf_rd_idx = '0;
        if (!busy) begin
          state_d = StPayload;
          data_d  = buf_rd_byte;
          idx_d   = LEN_W'(1);
        end
      end

      StPayload: begin
        // idx points at the byte that follows the one currently on data_out.
        if (!busy) begin
          if (idx_q < len_q) begin
            data_d = buf_rd_byte;
            idx_d  = idx_q + LEN_W'(1);
          end else begin
            state_d     = StParity;
            pkt_valid_d = 1'b0;
            data_d      = par_q;
          end
        end
      end

      StParity: begin
        if (!busy) begin
          state_d = StErrWait;
          data_d  = '0;
          cnt_d   = CntW'(ERR_WAIT);
          flag_d  = 1'b0;
        end
      end

      StErrWait: begin
        flag_d = flag_q | err;
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          done_d  = 1'b1;
          terr_d  = flag_q | err;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // State register with synchronous reset; buffer contents are left alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      par_q       <= '0;
      cnt_q       <= '0;
      flag_q      <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_q      <= '0;
      reject_q    <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      flag_q      <= flag_d;
      pkt_valid_q <= pkt_valid_d;
      data_q      <= data_d;
      reject_q    <= reject_d;
      done_q      <= done_d;
      terr_q      <= terr_d;
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Scoreboard bench for router_pkt_tx: expected bytes are queued when a packet is issued and
// checked as the router side consumes them.
module tb_router_pkt_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_reject;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       busy;
  logic       err;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_done;
  logic       tx_err;

  router_pkt_tx dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_reject (cmd_reject),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .busy       (busy),
    .err        (err),
    .pkt_valid  (pkt_valid),
    .data_out   (data_out),
    .tx_done    (tx_done),
    .tx_err     (tx_err)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int par_cyc = 0;
  int n_done  = 0;
  bit in_pkt  = 1'b0;

  logic [8:0] exp_q[$];     // {pkt_valid, data_out}
  bit         exp_err_q[$];
  logic [7:0] pbuf [64];
  int         stall [66];   // busy cycles before each of header, payload..., parity

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Router-side monitor: compares the presented byte each cycle, consumes it when busy is low.
  always @(negedge clock) begin : mon
    logic [8:0] e;
    bit         xe;
    if (reset) begin
      in_pkt = 1'b0;
      exp_q.delete();
      exp_err_q.delete();
    end else begin
      if (pkt_valid) in_pkt = 1'b1;
      if (in_pkt) begin
        if (exp_q.size() == 0) begin
          check_val("extra_byte", 32'(exp_q.size()), 32'd1);
          in_pkt = 1'b0;
        end else begin
          e = exp_q[0];
          check_val(busy ? "hold_byte" : "tx_byte", {23'd0, pkt_valid, data_out}, {23'd0, e});
          if (!busy) begin
            void'(exp_q.pop_front());
            if (!e[8]) begin
              in_pkt  = 1'b0;
              par_cyc = cyc;
            end
          end
        end
      end
      if (tx_done) begin
        n_done++;
        if (exp_err_q.size() == 0) begin
          check_val("extra_done", 32'(exp_err_q.size()), 32'd1);
        end else begin
          xe = exp_err_q.pop_front();
          check_val("tx_err", 32'(tx_err), 32'(xe));
          check_val("done_latency", 32'(cyc - par_cyc), 32'd4);
        end
      end
    end
  end

  task automatic fill_pkt(input logic [1:0] a, input int len, input bit inject);
    logic [7:0] hdr;
    logic [7:0] par;
    bit         rdy;
    int         t;
    hdr = {6'(len), a};
    par = hdr;
    exp_q.push_back({1'b1, hdr});
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({1'b1, pbuf[i]});
      par = par ^ pbuf[i];
    end
    exp_q.push_back({1'b0, par});
    exp_err_q.push_back(inject);

    cmd_addr  = a;
    cmd_len   = 6'(len);
    cmd_valid = 1'b1;
    @(negedge clock);
    check_val("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;

    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b0;
        @(posedge clock); #1;
      end
      wr_valid = 1'b1;
      wr_data  = pbuf[i];
      t = 0;
      do begin
        @(negedge clock);
        rdy = wr_ready;
        if (i == 0 && t == 0) check_val("cmd_ready_fill", 32'(cmd_ready), 32'd0);
        @(posedge clock); #1;
        t++;
      end while (!rdy && t < 10);
      check_val("wr_ready", 32'(rdy), 32'd1);
    end
    wr_valid = 1'b0;
  endtask

  task automatic tx_pkt(input int len, input bit inject);
    int d0;
    int t;
    d0 = n_done;
    for (int k = 0; k < len + 2; k++) begin
      busy = 1'b1;
      repeat (stall[k]) begin
        @(posedge clock); #1;
      end
      busy = 1'b0;
      @(posedge clock); #1;
    end
    if (inject) begin
      @(posedge clock); #1;
      err = 1'b1;
      @(posedge clock); #1;
      err = 1'b0;
    end
    t = 0;
    while (n_done == d0 && t < 20) begin
      @(posedge clock); #1;
      t++;
    end
    check_val("tx_done_seen", 32'(n_done - d0), 32'd1);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic send_pkt(input logic [1:0] a, input int len, input bit inject);
    fill_pkt(a, len, inject);
    tx_pkt(len, inject);
  endtask

  task automatic bad_cmd(input logic [1:0] a, input logic [5:0] len);
    cmd_addr  = a;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    check_val("reject_pulse", 32'(cmd_reject), 32'd1);
    check_val("reject_wr_ready", 32'(wr_ready), 32'd0);
    check_val("reject_pkt_valid", 32'(pkt_valid), 32'd0);
    @(posedge clock); #1;
    check_val("reject_clear", 32'(cmd_reject), 32'd0);
    check_val("reject_idle", 32'(cmd_ready), 32'd1);
  endtask

  task automatic clear_stall();
    for (int k = 0; k < 66; k++) stall[k] = 0;
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    busy      = 1'b0;
    err       = 1'b0;
    clear_stall();
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("rst_wr_ready", 32'(wr_ready), 32'd0);
    check_val("rst_pkt_valid", 32'(pkt_valid), 32'd0);
    check_val("rst_data_out", 32'(data_out), 32'd0);
    check_val("rst_tx_done", 32'(tx_done), 32'd0);
    check_val("rst_tx_err", 32'(tx_err), 32'd0);
    check_val("rst_cmd_reject", 32'(cmd_reject), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Basic: header 0D, payload 11 22 33, parity 0D.
    pbuf[0] = 8'h11; pbuf[1] = 8'h22; pbuf[2] = 8'h33;
    send_pkt(2'd1, 3, 1'b0);

    // Header held for five busy cycles.
    clear_stall();
    stall[0] = 5;
    send_pkt(2'd1, 3, 1'b0);

    // Stall on byte 22 and on the parity byte.
    clear_stall();
    stall[2] = 2;
    stall[4] = 2;
    send_pkt(2'd1, 3, 1'b0);

    // Illegal commands.
    bad_cmd(2'd1, 6'd0);
    bad_cmd(2'd3, 6'd5);

    // Router error inside the watch window.
    clear_stall();
    pbuf[0] = 8'hA5; pbuf[1] = 8'h3C; pbuf[2] = 8'h7E;
    send_pkt(2'd2, 3, 1'b1);

    // Maximum length with random data and stalls.
    for (int i = 0; i < 63; i++) pbuf[i] = 8'($urandom_range(0, 255));
    for (int k = 0; k < 65; k++) stall[k] = $urandom_range(0, 2);
    send_pkt(2'd2, 63, 1'b0);

    // Reset in the middle of the payload.
    clear_stall();
    for (int i = 0; i < 5; i++) pbuf[i] = 8'(8'h40 + i);
    fill_pkt(2'd1, 5, 1'b0);
    busy = 1'b0;
    repeat (3) begin
      @(posedge clock); #1;
    end
    reset = 1'b1;
    busy  = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    busy  = 1'b0;
    check_val("midrst_pkt_valid", 32'(pkt_valid), 32'd0);
    check_val("midrst_data_out", 32'(data_out), 32'd0);
    check_val("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
    check_val("midrst_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clock); #1;
    check_val("midrst_no_parity", {23'd0, pkt_valid, data_out}, 32'd0);

    pbuf[0] = 8'h5A;
    send_pkt(2'd0, 1, 1'b0);

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (failed so far %0d)", n_fail);
    $fatal(1);
  end

endmodule
